// File: rtl/vga_block_framebuffer_if.sv
// ============================================================================
// Module   : vga_block_framebuffer_if
// Purpose  : Host tile-write port for the block-mapped VGA framebuffer.
//            A write is accepted in any cycle where wr_valid & wr_ready.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_block_framebuffer_if #(
  parameter int ADDR_W = 11,
  parameter int BPP    = 6
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [BPP-1:0]    wr_data;

  // Host side drives the request, framebuffer answers with ready.
  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

`default_nettype wire

// File: rtl/vga_block_framebuffer.sv
// ============================================================================
// Module   : vga_block_framebuffer
// Purpose  : Parametrised block-mapped VGA framebuffer. Raster counters,
//            a tile memory of BLOCK x BLOCK pixel tiles and a two-stage
//            pixel pipeline whose syncs, de and rgb share one latency.
//            Host writes are accepted only while the raster is blanking.
// Options  : DOUBLE_BUFFER_EN - two tile banks, host writes the back bank,
//            swap_req/swap_ack/front_bank flip banks at the end of a frame.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_block_framebuffer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int BLOCK_LOG2 = 4,
  parameter int BPP        = 6,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_block_framebuffer_if.slave wr,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [BPP-1:0]         rgb,
  output logic                   frame_start
`ifdef DOUBLE_BUFFER_EN
  ,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   front_bank
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BLK_X   = H_ACTIVE >> BLOCK_LOG2;
  localparam int BLK_Y   = V_ACTIVE >> BLOCK_LOG2;
  localparam int DEPTH   = BLK_X * BLK_Y;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
`ifdef DOUBLE_BUFFER_EN
  localparam int NBANK   = 2;
`else
  localparam int NBANK   = 1;
`endif
  localparam int MEM_AW  = $clog2(NBANK * DEPTH);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  // ---------------- stage 0: raster counters ----------------
  logic [HC_W-1:0] h_cnt_q, h_cnt_d;
  logic [VC_W-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]     w_h, w_v;
  logic            w_hs0, w_vs0, w_vis0, w_fs0;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_h = 32'(h_cnt_q);
  assign w_v = 32'(v_cnt_q);

  // Next raster position: h wraps into a v increment, v wraps at frame end.
  always_comb begin
    h_cnt_d = h_cnt_q + HC_W'(1);
    v_cnt_d = v_cnt_q;
    if (w_h == H_TOTAL - 1) begin
      h_cnt_d = '0;
      if (w_v == V_TOTAL - 1) v_cnt_d = '0;
      else                    v_cnt_d = v_cnt_q + VC_W'(1);
    end
  end

  // Raster position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign w_hs0  = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
  assign w_vs0  = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
  assign w_vis0 = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign w_fs0  = (w_h == 0) && (w_v == 0);
  // Outside the visible area the tile index would run past DEPTH; park it at 0.
  assign w_rd_addr = w_vis0 ?
      ADDR_W'((w_v >> BLOCK_LOG2) * BLK_X + (w_h >> BLOCK_LOG2)) : '0;

  // ---------------- bank selection ----------------
  logic w_rd_bank, w_wr_bank;
`ifdef DOUBLE_BUFFER_EN
  logic front_q;
  logic w_frame_end;

  assign w_frame_end = (w_h == H_TOTAL - 1) && (w_v == V_TOTAL - 1);
  assign swap_ack    = ~rst & w_frame_end & swap_req;
  assign front_bank  = front_q;
  assign w_rd_bank   = front_q;
  assign w_wr_bank   = ~front_q;

  // Displayed bank flips on the last clock of the frame when a swap is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           front_q <= 1'b0;
    else if (swap_ack) front_q <= ~front_q;
  end
`else
  assign w_rd_bank = 1'b0;
  assign w_wr_bank = 1'b0;
`endif

  // ---------------- host write port ----------------
  logic w_wr_fire, w_wr_in_range;
  logic [MEM_AW-1:0] w_wr_idx, w_rd_idx;

  // Ready only in blanking, so reads and writes never touch the memory together.
  assign wr.wr_ready     = ~rst & ~w_vis0;
  assign w_wr_fire       = wr.wr_valid & ~rst & ~w_vis0;
  assign w_wr_in_range   = 32'(wr.wr_addr) < DEPTH;
  assign w_wr_idx        = MEM_AW'(32'(w_wr_bank) * DEPTH + 32'(wr.wr_addr));
  assign w_rd_idx        = MEM_AW'(32'(w_rd_bank) * DEPTH + 32'(w_rd_addr));

  // ---------------- stage 1: tile memory ----------------
  logic [BPP-1:0] mem_q [NBANK*DEPTH];
  logic [BPP-1:0] rd_data_q;

  // Tile memory: write on handshake (out-of-range addresses dropped), registered read.
  always_ff @(posedge clk) begin
    if (w_wr_fire && w_wr_in_range) mem_q[w_wr_idx] <= wr.wr_data;
    rd_data_q <= mem_q[w_rd_idx];
  end

  logic vis1_q, hs1_q, vs1_q, fs1_q;

  // Delay the raster flags alongside the memory read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vis1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      fs1_q  <= 1'b0;
    end else begin
      vis1_q <= w_vis0;
      hs1_q  <= w_hs0;
      vs1_q  <= w_vs0;
      fs1_q  <= w_fs0;
    end
  end

  // ---------------- stage 2: output registers ----------------
  logic           hsync_q, vsync_q, de_q, fs_q;
  logic [BPP-1:0] rgb_q;

  // Pin registers: apply sync polarity and blank colour outside the visible area.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= ~HS_ACT;
      vsync_q <= ~VS_ACT;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hs1_q ? HS_ACT : ~HS_ACT;
      vsync_q <= vs1_q ? VS_ACT : ~VS_ACT;
      de_q    <= vis1_q;
      rgb_q   <= vis1_q ? rd_data_q : '0;
      fs_q    <= fs1_q;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_block_framebuffer.sv
// ============================================================================
// Module   : tb_vga_block_framebuffer
// Purpose  : Randomised scoreboard bench for vga_block_framebuffer on a
//            reduced raster (64x40 total, 48x32 visible, 8x8 tiles, 24 tiles).
//            Build with DOUBLE_BUFFER_EN to exercise bank swapping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_block_framebuffer;
  localparam int H_ACTIVE = 48, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 32, V_FP = 2, V_SYNC = 2, V_BP = 4;
  localparam int BLOCK_LOG2 = 3, BPP = 6, HS_POL = 0, VS_POL = 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BLOCK   = 1 << BLOCK_LOG2;
  localparam int BLK_X   = H_ACTIVE / BLOCK;
  localparam int BLK_Y   = V_ACTIVE / BLOCK;
  localparam int DEPTH   = BLK_X * BLK_Y;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int FRAME   = H_TOTAL * V_TOTAL;
`ifdef DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic hsync, vsync, de, frame_start;
  logic [BPP-1:0] rgb;
`ifdef DOUBLE_BUFFER_EN
  logic swap_req = 1'b0;
  logic swap_ack, front_bank;
`endif

  vga_block_framebuffer_if #(.ADDR_W(ADDR_W), .BPP(BPP)) bus ();

  vga_block_framebuffer #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BLOCK_LOG2(BLOCK_LOG2), .BPP(BPP), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst(rst), .wr(bus),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
`ifdef DOUBLE_BUFFER_EN
    , .swap_req(swap_req), .swap_ack(swap_ack), .front_bank(front_bank)
`endif
  );

  int checks = 0, passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit hs; bit vs; bit de; bit fs; bit rgb_chk; int rgb; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   model_mem [NB][DEPTH];
  bit   known     [NB][DEPTH];
  int   model_front = 0;
  int   tk = 0;             // cycles since reset release = raster position index
  int   last_wr_h = -1, last_wr_v = -1, wr_count = 0, swap_count = 0;

  // Predicts each cycle's pins from the raster rules and tracks host writes.
  always @(negedge clk) begin
    if (!rst) begin
      int h, v, tile, wb;
      bit vis, hs_act, vs_act;
      exp_t e;
      h      = tk % H_TOTAL;
      v      = (tk / H_TOTAL) % V_TOTAL;
      vis    = (h < H_ACTIVE) && (v < V_ACTIVE);
      hs_act = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
      vs_act = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
      e.hs   = hs_act ? (HS_POL != 0) : (HS_POL == 0);
      e.vs   = vs_act ? (VS_POL != 0) : (VS_POL == 0);
      e.de   = vis;
      e.fs   = (h == 0) && (v == 0);
      e.rgb  = 0;
      e.rgb_chk = 1'b1;
      if (vis) begin
        tile      = (v / BLOCK) * BLK_X + (h / BLOCK);
        e.rgb     = model_mem[model_front][tile];
        e.rgb_chk = known[model_front][tile];
      end
      exp_q.push_back(e);
      chk("wr_ready", bus.wr_ready, !vis);
      if (bus.wr_valid && bus.wr_ready) begin
        last_wr_h = h;
        last_wr_v = v;
        wr_count++;
        wb = (NB == 2) ? 1 - model_front : 0;
        if (bus.wr_addr < DEPTH) begin
          model_mem[wb][bus.wr_addr] = bus.wr_data;
          known[wb][bus.wr_addr]     = 1'b1;
        end
      end
`ifdef DOUBLE_BUFFER_EN
      chk("front_bank", front_bank, model_front);
      chk("swap_ack", swap_ack, (h == H_TOTAL - 1) && (v == V_TOTAL - 1) && swap_req);
      if ((h == H_TOTAL - 1) && (v == V_TOTAL - 1) && swap_req) begin
        model_front = 1 - model_front;
        swap_count++;
      end
`endif
      tk++;
    end
  end

  // Monitor: pins appear two cycles after the raster position that produced them.
  always @(negedge clk) begin
    #1;
    if (!rst && exp_q.size() > 2) begin
      mon_e = exp_q.pop_front();
      chk("hsync", hsync, mon_e.hs);
      chk("vsync", vsync, mon_e.vs);
      chk("de", de, mon_e.de);
      chk("frame_start", frame_start, mon_e.fs);
      if (mon_e.rgb_chk) chk("rgb", rgb, mon_e.rgb);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input int addr, input int data);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_W'(addr);
    bus.wr_data  = BPP'(data);
    forever begin
      @(negedge clk);
      if (bus.wr_ready === 1'b1) break;
      n++;
      if (n > 2 * FRAME) begin
        fail_now("write_handshake");
        break;
      end
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  // Returns at posedge+1 with the DUT counters sitting on (h, v).
  task automatic wait_pos(input int h, input int v);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(((tk % H_TOTAL) == h) && (((tk / H_TOTAL) % V_TOTAL) == v)) && n <= 2 * FRAME);
    if (n > 2 * FRAME) fail_now("wait_pos");
  endtask

  task automatic two_edges();
    repeat (2) begin @(posedge clk); #1; end
  endtask

`ifdef DOUBLE_BUFFER_EN
  task automatic do_swap();
    int n = 0;
    int c0 = swap_count;
    swap_req = 1'b1;
    while (swap_count == c0 && n <= 2 * FRAME) begin
      @(posedge clk); #1;
      n++;
    end
    swap_req = 1'b0;
    if (swap_count == c0) fail_now("swap_ack_wait");
  endtask
`endif

  task automatic fill_back_random();
    for (int t = 0; t < DEPTH; t++) do_write(t, int'($urandom_range(0, (1 << BPP) - 1)));
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_hsync"}, hsync, HS_POL == 0);
    chk({tag, "_vsync"}, vsync, VS_POL == 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_wr_ready"}, bus.wr_ready, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt_hs, cnt_vs, cnt_de, cnt_fs, wc0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    #1 rst = 1'b1;
    #11;
    check_reset_pins("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Load every tile (both banks when double buffered).
    fill_back_random();
`ifdef DOUBLE_BUFFER_EN
    do_swap();
    fill_back_random();
`endif

    // Sync/de duty over one whole frame.
    wait_pos(0, 0);
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0;
    repeat (FRAME) begin
      @(posedge clk); #1;
      if (hsync == (HS_POL != 0)) cnt_hs++;
      if (vsync == (VS_POL != 0)) cnt_vs++;
      if (de) cnt_de++;
      if (frame_start) cnt_fs++;
    end
    chk("hsync_active_cycles", cnt_hs, H_SYNC * V_TOTAL);
    chk("vsync_active_cycles", cnt_vs, V_SYNC * H_TOTAL);
    chk("de_cycles", cnt_de, H_ACTIVE * V_ACTIVE);
    chk("frame_start_count", cnt_fs, 1);

`ifndef DOUBLE_BUFFER_EN
    // Two tiles written in blanking appear in the next frame, two clocks late.
    do_write(0, 'h3F);
    do_write(1, 'h15);
    wait_pos(0, 0);
    two_edges();
    chk("px00_de", de, 1);
    chk("px00_frame_start", frame_start, 1);
    chk("px00_rgb", rgb, 'h3F);
    wait_pos(BLOCK - 1, BLOCK - 1);
    two_edges();
    chk("tile0_corner_rgb", rgb, 'h3F);
    wait_pos(BLOCK, 0);
    two_edges();
    chk("tile1_first_rgb", rgb, 'h15);
`endif

    // Write held across a visible line completes at the first blanking cycle.
    wait_pos(0, 5);
    do_write(3, int'($urandom_range(0, 63)));
    chk("stall_release_h", last_wr_h, H_ACTIVE);
    chk("stall_release_v", last_wr_v, 5);

    // Out-of-range address: handshake completes, no tile changes.
    wc0 = wr_count;
    do_write(DEPTH, 'h2A);
    do_write((1 << ADDR_W) - 1, 'h11);
    chk("oob_handshakes", wr_count - wc0, 2);

    // Mid-frame reset with a write pending.
    wait_pos(30, 20);
    rst = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = '0;
    bus.wr_data  = BPP'(~model_mem[0][0]);
    #1;
    check_reset_pins("midreset");
    exp_q.delete();
    tk = 0;
    model_front = 0;
    repeat (3) @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_1clk_de", de, 0);
    chk("post_rst_1clk_frame_start", frame_start, 0);
    @(posedge clk); #1;
    chk("post_rst_2clk_de", de, 1);
    chk("post_rst_2clk_frame_start", frame_start, 1);

`ifdef DOUBLE_BUFFER_EN
    // Back bank filled with 0x0C, swapped in at frame end.
    for (int t = 0; t < DEPTH; t++) do_write(t, 'h0C);
    do_swap();
    @(negedge clk);
    chk("front_after_swap", front_bank, 1);
    wait_pos(0, 0);
    two_edges();
    chk("swapped_rgb", rgb, 'h0C);
    // Back bank changes without a swap must not reach the screen.
    fill_back_random();
    wait_pos(0, 0);
    wait_pos(0, 0);
    two_edges();
    chk("noswap_front", front_bank, 1);
    chk("noswap_rgb", rgb, 'h0C);
`endif

    // Let the scoreboard run over another full frame.
    repeat (FRAME + 4) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
